// File: rtl/mio_bus_responder_pkg.sv
// rtl/mio_bus_responder_pkg.sv - shared types, address map and decode helper for the MIO bus responder
//
// Purpose: FSM state encoding, target region encoding, address-map constants
//          and the word-address decode function used by the responder top.
// Ports:   none (package).

package mio_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RGN_RAM  = 3'd0,
        RGN_LED  = 3'd1,
        RGN_SW   = 3'd2,
        RGN_CNT  = 3'd3,
        RGN_NONE = 3'd4
    } region_t;

    localparam logic [3:0]  RAM_REGION    = 4'h0;
    localparam logic [31:0] LED_ADDR      = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR       = 32'hE000_0004;
    localparam logic [31:0] CNT_ADDR      = 32'hF000_0000;
    localparam logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF;

    // Takes the word address (byte address bits [31:2]); byte-lane bits never
    // influence the decode because all accesses are whole words.
    function automatic region_t decode_region(input logic [29:0] word_addr);
        region_t rgn;
        if (word_addr[29:26] == RAM_REGION) begin
            rgn = RGN_RAM;
        end else if (word_addr == LED_ADDR[31:2]) begin
            rgn = RGN_LED;
        end else if (word_addr == SW_ADDR[31:2]) begin
            rgn = RGN_SW;
        end else if (word_addr == CNT_ADDR[31:2]) begin
            rgn = RGN_CNT;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mio_word_ram.sv
// rtl/mio_word_ram.sv - single-port synchronous write-first word RAM
//
// Purpose: 2^AW x 32 storage behind the responder's RAM region; block-RAM
//          inferrable (no reset on contents or read register).
// Ports:
//   clk    in   clock
//   en     in   access enable; read register only changes when en = 1
//   we     in   write enable (with en); read data then returns the new word
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data

module mio_word_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - MIO bus slave serving word RAM, LED/switch registers and a cycle counter
//
// Purpose: accepts one CPU request at a time, waits WAIT_CYCLES, then performs
//          the access and pulses mio_ready for one cycle.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   cpu_mio    in   request valid
//   mem_w      in   1 = write, 0 = read
//   addr_in    in   byte address
//   wdata_in   in   write data
//   rdata_out  out  read data, valid with mio_ready and held afterwards
//   mio_ready  out  one-cycle completion pulse
//   busy       out  high from acceptance until the cycle after mio_ready
//   sw_in      in   switch inputs
//   led_out    out  LED register

module mio_bus_responder
    import mio_bus_responder_pkg::*;
#(
    parameter int RAM_AW      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_mio,
    input  logic             mem_w,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      wdata_in,
    output logic [31:0]      rdata_out,
    output logic             mio_ready,
    output logic             busy,
    input  logic [LED_W-1:0] sw_in,
    output logic [LED_W-1:0] led_out
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic        accept, enter_resp;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q, wdata_q;
    logic        mem_w_q;
    logic [31:0] cur_addr, cur_wdata;
    logic        cur_we;
    region_t     cur_region;
    logic [31:0] cnt;
    logic [31:0] rdata_q;
    logic        rd_from_ram;
    logic        busy_q;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_mio) begin
                    accept = 1'b1;
                    if (WAIT_INIT == 4'd0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= addr_in;
            wdata_q  <= wdata_in;
            mem_w_q  <= mem_w;
            wait_cnt <= WAIT_INIT;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // With zero wait states the access happens on the acceptance edge itself,
    // before the latch holds the request, so IDLE looks straight at the bus.
    assign cur_addr    = (state == ST_IDLE) ? addr_in  : addr_q;
    assign cur_wdata   = (state == ST_IDLE) ? wdata_in : wdata_q;
    assign cur_we      = (state == ST_IDLE) ? mem_w    : mem_w_q;
    assign cur_region  = decode_region(cur_addr[31:2]);
    assign unused_bits = ^cur_addr[1:0];

    // The RAM is clocked on the edge into RESP so its output lines up with mio_ready.
    assign ram_en = enter_resp && (cur_region == RGN_RAM) && !reset;

    mio_word_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (cur_we),
        .addr (cur_addr[RAM_AW+1:2]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else if (enter_resp && cur_we && (cur_region == RGN_LED)) begin
            led_out <= cur_wdata[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (enter_resp && cur_we && (cur_region == RGN_CNT)) begin
            cnt <= cur_wdata;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // Read data comes either straight from the RAM register or from a holding
    // register. A write freezes whatever is currently visible into the holding
    // register, since write-first RAM output would otherwise change rdata_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= '0;
            rd_from_ram <= 1'b0;
        end else if (enter_resp) begin
            if (cur_we) begin
                rdata_q     <= rdata_out;
                rd_from_ram <= 1'b0;
            end else begin
                rd_from_ram <= (cur_region == RGN_RAM);
                case (cur_region)
                    RGN_LED: rdata_q <= 32'(led_out);
                    RGN_SW:  rdata_q <= 32'(sw_in);
                    RGN_CNT: rdata_q <= cnt;
                    RGN_RAM: rdata_q <= rdata_q;
                    default: rdata_q <= DEFAULT_RDATA;
                endcase
            end
        end
    end

    assign rdata_out = rd_from_ram ? ram_rdata : rdata_q;

    // busy stays up one cycle past RESP, covering the turnaround cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= accept || (state != ST_IDLE);
        end
    end

    assign busy      = busy_q;
    assign mio_ready = (state == ST_RESP);

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO responder on the CPU's MIO bus; the slave side of the pipelined core's data-memory port.
- Accepts one request at a time, qualified by cpu_mio, with address, write data and mem_w.
- Serves the request from on-chip word RAM, an LED/switch register pair, or a free-running cycle counter.
- Completes each request with a one-cycle mio_ready pulse after a programmable number of wait states.

Parameters:
- RAM_AW, 10: RAM word-address width (depth 2^RAM_AW 32-bit words).
- WAIT_CYCLES, 2: wait states inserted between acceptance and response; 0..15.
- LED_W, 16: width of the LED output and switch input.

Ports:
- clk  in  1: system clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset.
- cpu_mio  in  1: request valid; held high by the CPU until mio_ready.
- mem_w  in  1: 1 = write, 0 = read; sampled with cpu_mio.
- addr_in  in  32: byte address from the CPU.
- wdata_in  in  32: write data from the CPU.
- rdata_out  out  32: read data to the CPU; valid when mio_ready = 1.
- mio_ready  out  1: single-cycle completion pulse.
- busy  out  1: high from acceptance until the cycle after the mio_ready pulse.
- sw_in  in  LED_W: switch inputs.
- led_out  out  LED_W: LED register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: FSM = IDLE; mio_ready = 0; busy = 0; rdata_out = 0; led_out = 0; counter = 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cpu_mio = 1 → latch addr_in, wdata_in and mem_w; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT, or RESP directly when WAIT_CYCLES = 0.
- WAIT: decrement the wait counter each cycle; go to RESP when it reaches 1.
- RESP:
  - mio_ready = 1 for exactly this cycle.
  - The access is performed on entry, from the latched request.
  - Next state is IDLE.
- Latency: acceptance at cycle T gives mio_ready at T + WAIT_CYCLES + 1.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP. IDLE ignores cpu_mio for that one cycle, so the minimum request spacing is WAIT_CYCLES + 2 cycles (a one-cycle turnaround).
- Address decode (latched address, bits [1:0] ignored, word access only):
  - addr[31:28] = 0x0: RAM word addr[RAM_AW+1:2]. Upper bits alias.
  - 0xE0000000: LED register, read/write; write stores wdata[LED_W-1:0].
  - 0xE0000004: switches, read-only; read returns sw_in zero-extended; write ignored.
  - 0xF0000000: counter, read/write.
  - Any other address: read returns 0xDEADBEEF; write ignored. mio_ready still pulses, so the bus never hangs.
- Read data:
  - rdata_out updates when entering RESP and holds its value afterwards.
  - RAM is read synchronously; the read address is presented in the cycle before RESP.
  - A write leaves rdata_out unchanged.
- Counter:
  - 32-bit, increments every cycle.
  - Wraps 0xFFFFFFFF → 0.
  - A write loads wdata, and the write wins over the increment that cycle.
  - A read returns the value at RESP entry.
- Request dropped early: if cpu_mio falls during WAIT, the latched request still completes and mio_ready still pulses.
- Reset mid-operation: an in-flight request is discarded with no mio_ready and no write side effect.
- Sampling: inputs are sampled only in IDLE; changes on addr_in or wdata_in after acceptance are ignored.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Region/offset constants: 4'h0, 32'hE0000000, 32'hE0000004, 32'hF0000000.
  - Default read value 32'hDEADBEEF.
- One sub-module: mio_word_ram.
  - Single-port synchronous RAM, 2^RAM_AW × 32, write-first.
  - Inferrable as block RAM.
- Decode, FSM, LED register and counter stay in the top module.

Test Plan:
- Reset released, WAIT_CYCLES = 2; write 0x12345678 to 0x00000010, then read 0x00000010 → each mio_ready 3 cycles after acceptance; read returns 0x12345678; busy high 4 cycles per request.
- WAIT_CYCLES = 0; back-to-back RAM reads with cpu_mio held high → mio_ready every 2nd cycle, one cycle after acceptance.
- Write 0x0000A5A5 to 0xE0000000 → led_out = 0xA5A5 after RESP. Read 0xE0000004 with sw_in = 0x00FF → rdata 0x000000FF. Write 0xE0000004 → led_out unchanged.
- Write 0xFFFFFFFE to 0xF0000000, then read after WAIT_CYCLES + 2 cycles → value consistent with increment-per-cycle and wraparound through 0.
- Read 0x40000000 → 0xDEADBEEF with mio_ready pulse; write to 0x40000000 → no RAM, LED or counter change.
- Assert reset during WAIT of a write to 0x00000020 → no mio_ready; RAM word 8 is not written; led_out = 0 and counter = 0 on the cycle after reset.
